fifo_read_unpacker: RTL and testbench

Read-clock-domain consumer placed directly downstream of the asynchronous FIFO. It pops bytes whenever the FIFO reports non-empty and packs PACK consecutive bytes into one wide word. The packed word is presented on a valid/ready output port. An optional sequence checker verifies the incoming stream against the transmitter's pattern, where byte n equals 2*n mod 2^W.

---
 rtl/fifo_read_unpacker_if.sv | 22 ++
 rtl/fifo_read_unpacker.sv | 88 ++++++++
 tb/tb_fifo_read_unpacker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_unpacker_if.sv
// Handshake bundle for fifo_read_unpacker: FIFO pop side plus the packed-word valid/ready side.
interface fifo_read_unpacker_if #(
  parameter int W    = 8,
  parameter int PACK = 4
);
  logic            r_empty;
  logic [W-1:0]    data_in;
  logic            rd_en;
  logic [W*PACK-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    input  r_empty, data_in, out_ready,
    output rd_en, out_data, out_valid
  );

  modport slave (
    output r_empty, data_in, out_ready,
    input  rd_en, out_data, out_valid
  );
endinterface

// File: rtl/fifo_read_unpacker.sv
// Pops bytes from the async FIFO read side and packs PACK of them into one valid/ready word.
// Optional stream checker (byte n == 2*n mod 2^W) is built when FIFO_RD_CHECK_EN is defined.
module fifo_read_unpacker #(
  parameter int W     = 8,
  parameter int PACK  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 read_clk,
  input  logic                 reset,
  fifo_read_unpacker_if.master bus,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 err_flag
);
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q, state_d;
  logic [LANE_W-1:0]     lane;
  logic [W*(PACK-1)-1:0] acc;
  logic                  stall, pop, pop_last, accept;

  always_comb begin
    stall    = (lane == LAST_LANE) & bus.out_valid & ~bus.out_ready;
    pop      = reset & ~bus.r_empty & ~stall;
    pop_last = pop & (lane == LAST_LANE);
    accept   = bus.out_valid & bus.out_ready;
  end

  assign bus.rd_en     = pop;
  assign bus.out_valid = (state_q == HOLD);

  always_ff @(posedge read_clk) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  // A completing word while the previous one is being accepted keeps us in HOLD (no bubble).
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (pop_last) state_d = HOLD;
      HOLD:    if (accept && !pop_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (!reset) begin
      lane         <= '0;
      acc          <= '0;
      bus.out_data <= '0;
      word_count   <= '0;
    end else begin
      if (pop) lane <= pop_last ? '0 : lane + 1'b1;
      for (int i = 0; i < PACK - 1; i++) begin
        if (pop && lane == LANE_W'(i)) acc[i*W +: W] <= bus.data_in;
      end
      if (pop_last) bus.out_data <= {bus.data_in, acc};
      if (accept)   word_count   <= word_count + 1'b1;
    end
  end

`ifdef FIFO_RD_CHECK_EN
  logic [W-1:0] expected;

  // Resync on mismatch so a single corrupted byte is counted once.
  always_ff @(posedge read_clk) begin
    if (!reset) begin
      expected  <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (pop) begin
      expected <= bus.data_in + W'(2);
      if (bus.data_in != expected) begin
        err_flag <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end
`else
  assign err_count = '0;
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_unpacker.sv
// Scoreboard bench for fifo_read_unpacker: FIFO model feeds bytes, negedge monitor checks accepted words.
module tb_fifo_read_unpacker;
  localparam int W = 8, PACK = 4, CNT_W = 16;
`ifdef FIFO_RD_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic             read_clk = 1'b0;
  logic             reset    = 1'b0;
  logic [CNT_W-1:0] word_count, err_count;
  logic             err_flag;

  fifo_read_unpacker_if #(.W(W), .PACK(PACK)) bus ();

  fifo_read_unpacker #(.W(W), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .read_clk   (read_clk),
    .reset      (reset),
    .bus        (bus),
    .word_count (word_count),
    .err_count  (err_count),
    .err_flag   (err_flag)
  );

  always #5 read_clk = ~read_clk;

  logic [W-1:0]      src_q[$];
  logic [W*PACK-1:0] sb[$];
  logic              pop_now = 1'b0;
  logic              toggle  = 1'b0;
  logic              gate    = 1'b0;
  int                pops = 0, first_pop = 0, last_pop = 0, cyc = 0;
  int                n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // FIFO model: pops on the edge where rd_en was seen high, then presents the next head.
  initial begin
    forever begin
      @(posedge read_clk);
      cyc++;
      if (pop_now) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      #1;
      gate        = toggle ? ~gate : 1'b0;
      bus.r_empty = gate || (src_q.size() == 0);
      bus.data_in = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  // Monitor: the word is accepted on the next rising edge when valid & ready are high here.
  always @(negedge read_clk) begin
    if (reset) begin
      if (bus.r_empty) check("rd_en_while_empty", 64'(bus.rd_en), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got %0h, want none", bus.out_data);
        end else begin
          check("out_data", 64'(bus.out_data), 64'(sb.pop_front()));
        end
      end
      pop_now <= bus.rd_en;
    end else begin
      check("rd_en_in_reset", 64'(bus.rd_en), 64'd0);
      pop_now <= 1'b0;
    end
  end

  task automatic push_bytes(input int first, input int count);
    for (int n = 0; n < count; n++) src_q.push_back(W'((first + n) * 2));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge read_clk);
    src_q.delete();
    @(posedge read_clk);
    #2;
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((src_q.size() != 0 || sb.size() != 0) && n < budget) begin
      @(posedge read_clk);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      $display("FAIL timeout_%s: got %0d pending, want 0", name, src_q.size() + sb.size());
    end
    repeat (3) @(posedge read_clk);
    #2;
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int n = 0;
    while (pops < target && n < budget) begin
      @(posedge read_clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      $display("FAIL timeout_%s: got %0d pops, want %0d", name, pops, target);
    end
  endtask

  initial begin
    bus.r_empty   = 1'b1;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;
    do_reset();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_err_flag", 64'(err_flag), 64'd0);

    // Streaming at full rate, two words.
    pops = 0;
    push_bytes(0, 8);
    sb.push_back(32'h06040200);
    sb.push_back(32'h0E0C0A08);
    wait_idle("t1", 100);
    check("t1_pops", 64'(pops), 64'd8);
    check("t1_consecutive", 64'(last_pop - first_pop), 64'd7);
    check("t1_word_count", 64'(word_count), 64'd2);
    check("t1_err_count", 64'(err_count), 64'd0);

    // Backpressure: stall at the last lane until out_ready rises.
    bus.out_ready = 1'b0;
    pops = 0;
    push_bytes(8, 8);
    sb.push_back(32'h16141210);
    sb.push_back(32'h1E1C1A18);
    wait_pops("t2", 7, 100);
    repeat (3) @(posedge read_clk);
    #2;
    check("t2_pops_stalled", 64'(pops), 64'd7);
    check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    check("t2_held_data", 64'(bus.out_data), 64'h16141210);
    check("t2_rd_en_stall", 64'(bus.rd_en), 64'd0);
    check("t2_r_empty", 64'(bus.r_empty), 64'd0);
    check("t2_wc_held", 64'(word_count), 64'd2);
    bus.out_ready = 1'b1;
    @(posedge read_clk);
    #2;
    check("t2_same_edge_pop", 64'(pops), 64'd8);
    check("t2_wc_inc", 64'(word_count), 64'd3);
    check("t2_back_to_back", 64'(bus.out_valid), 64'd1);
    wait_idle("t2", 100);
    check("t2_word_count", 64'(word_count), 64'd4);

    // Empty gaps every other cycle; partial word must be held.
    do_reset();
    toggle = 1'b1;
    pops = 0;
    push_bytes(0, 3);
    wait_pops("t3", 3, 100);
    repeat (6) @(posedge read_clk);
    #2;
    check("t3_partial_no_valid", 64'(bus.out_valid), 64'd0);
    check("t3_partial_wc", 64'(word_count), 64'd0);
    push_bytes(3, 1);
    sb.push_back(32'h06040200);
    wait_idle("t3", 100);
    toggle = 1'b0;
    check("t3_word_count", 64'(word_count), 64'd1);

    // Reset mid-word discards the partial accumulator.
    pops = 0;
    push_bytes(4, 2);
    wait_pops("t4", 2, 100);
    push_bytes(6, 2);
    do_reset();
    check("t4_out_data", 64'(bus.out_data), 64'd0);
    check("t4_out_valid", 64'(bus.out_valid), 64'd0);
    check("t4_word_count", 64'(word_count), 64'd0);
    push_bytes(0, 4);
    sb.push_back(32'h06040200);
    wait_idle("t4", 100);
    check("t4_wc_after", 64'(word_count), 64'd1);
    check("t4_err_count", 64'(err_count), 64'd0);

    // Sequence checker: 0,2,5,7,9 has one mismatch, then resyncs.
    do_reset();
    src_q.push_back(8'd0);
    src_q.push_back(8'd2);
    wait_idle("t5a", 100);
    check("t5_err_before", 64'(err_count), 64'd0);
    src_q.push_back(8'd5);
    wait_idle("t5b", 100);
    check("t5_err_count", 64'(err_count), 64'(EXP_ERR));
    check("t5_err_flag", 64'(err_flag), 64'(EXP_ERR));
    src_q.push_back(8'd7);
    src_q.push_back(8'd9);
    sb.push_back(32'h07050200);
    wait_idle("t5c", 100);
    check("t5_err_resync", 64'(err_count), 64'(EXP_ERR));
    check("t5_word_count", 64'(word_count), 64'd1);

    // Full 256-byte pattern, expected value wraps 254 -> 0.
    do_reset();
    push_bytes(0, 256);
    for (int k = 0; k < 64; k++) begin
      logic [31:0] w;
      for (int b = 0; b < 4; b++) w[b*8 +: 8] = 8'((4 * k + b) * 2);
      sb.push_back(w);
    end
    wait_idle("t6", 2000);
    check("t6_word_count", 64'(word_count), 64'd64);
    check("t6_err_count", 64'(err_count), 64'd0);
    check("t6_err_flag", 64'(err_flag), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "global timeout");
  end
endmodule
